// File: rtl/j1_io_console_if.sv
// I/O bus bundle for j1_io_console: j1 io_rd/io_wr/io_addr bus, TX byte drain
// stream and the exit request/code pair.
interface j1_io_console_if;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        exit_req;
    logic [7:0]  exit_code;

    modport master (
        output io_rd, io_wr, io_addr, io_dout, tx_ready,
        input  io_din, tx_data, tx_valid, exit_req, exit_code
    );

    modport slave (
        input  io_rd, io_wr, io_addr, io_dout, tx_ready,
        output io_din, tx_data, tx_valid, exit_req, exit_code
    );
endinterface

// File: rtl/j1_io_console.sv
// j1 I/O slave: buffered TX console, status, 32-bit cycle counter, drained exit.
// Define J1_IO_CONSOLE_SIM_EN to echo popped bytes and end simulation on exit.
module j1_io_console #(
    parameter logic [15:0] BASE      = 16'h2000,
    parameter logic [15:0] EXIT_ADDR = 16'hFFFF,
    parameter int          DEPTH     = 16,
    parameter int          LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    j1_io_console_if.slave bus
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic [31:0]      cycle;
    logic [15:0]      shadow;
    logic [15:0]      io_din_q;
    logic             exit_pending;
    logic             exit_req_q;
    logic [7:0]       exit_code_q;

    logic [16:0]      addr_off;
    logic             win_hit;
    logic [1:0]       reg_sel;
    logic             exit_hit;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_req;
    logic             push;
    logic             ovf_set;
    logic             ovf_clr;
    logic             exit_wr;
    logic             exit_fire;
    logic [15:0]      status;
    logic [15:0]      rd_data;

    // Window decode is done on a 17-bit difference so addresses below BASE
    // land far above 3 instead of wrapping into the window.
    always_comb begin
        addr_off   = {1'b0, bus.io_addr} - {1'b0, BASE};
        win_hit    = addr_off < 17'd4;
        reg_sel    = addr_off[1:0];
        exit_hit   = !win_hit && (bus.io_addr == EXIT_ADDR);
        fifo_empty = level == '0;
        fifo_full  = level == FULL_LVL;
        pop        = !fifo_empty && bus.tx_ready;
        push_req   = bus.io_wr && win_hit && (reg_sel == 2'd0);
        push       = push_req && (!fifo_full || pop);
        ovf_set    = push_req && !push;
        ovf_clr    = bus.io_wr && win_hit && (reg_sel == 2'd1) && bus.io_dout[15];
        exit_wr    = bus.io_wr && exit_hit && !exit_req_q;
        exit_fire  = exit_pending && fifo_empty && !push && !exit_req_q;
    end

    always_comb begin
        status              = '0;
        status[15]          = overflow;
        status[14]          = fifo_full;
        status[13]          = fifo_empty;
        status[12]          = exit_pending;
        status[LVL_W-1:0]   = level;
    end

    always_comb begin
        rd_data = '0;
        if (win_hit) begin
            case (reg_sel)
                2'd1:    rd_data = status;
                2'd2:    rd_data = cycle[15:0];
                2'd3:    rd_data = shadow;
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= bus.io_dout[7:0];
        end
    end

    // Pointers are PTR_W bits wide, so the +1 wraps mod DEPTH on its own.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + {{(LVL_W-1){1'b0}}, push} - {{(LVL_W-1){1'b0}}, pop};
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            cycle    <= '0;
            shadow   <= '0;
            io_din_q <= '0;
        end else begin
            cycle <= cycle + 32'd1;
            if (bus.io_rd) begin
                io_din_q <= rd_data;
                if (win_hit && (reg_sel == 2'd2)) begin
                    shadow <= cycle[31:16];
                end
            end
        end
    end

    // Exit is requested only once the FIFO is empty with nothing arriving.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            exit_pending <= 1'b0;
            exit_req_q   <= 1'b0;
            exit_code_q  <= '0;
        end else begin
            if (exit_wr) begin
                exit_pending <= 1'b1;
                exit_code_q  <= bus.io_dout[7:0];
            end
            if (exit_fire) begin
                exit_req_q <= 1'b1;
            end
        end
    end

    assign bus.io_din    = io_din_q;
    assign bus.tx_data   = mem[rd_ptr];
    assign bus.tx_valid  = !fifo_empty;
    assign bus.exit_req  = exit_req_q;
    assign bus.exit_code = exit_code_q;

`ifdef J1_IO_CONSOLE_SIM_EN
    always @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            if (pop) begin
                $write("%c", bus.tx_data);
            end
            if (exit_fire) begin
                $display("\n*EXIT* %02h", exit_code_q);
                $finish;
            end
        end
    end
`else
    // Synthesis build: console bytes leave only through the tx_* stream.
`endif

endmodule

// File: tb/tb_j1_io_console.sv
// Directed self-checking bench for j1_io_console (default DEPTH=16, BASE=0x2000).
module tb_j1_io_console;

    logic        clk;
    logic        rst;
    logic [31:0] model_cycle;
    int          assert_count;
    int          fail_count;

    j1_io_console_if bus ();

    j1_io_console #(
        .BASE      (16'h2000),
        .EXIT_ADDR (16'hFFFF),
        .DEPTH     (16)
    ) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .bus       (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference cycle count: zero in reset, +1 on every edge afterwards.
    always @(posedge clk or posedge rst) begin
        if (rst) model_cycle <= '0;
        else     model_cycle <= model_cycle + 32'd1;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data);
        bus.io_wr   = 1'b1;
        bus.io_addr = addr;
        bus.io_dout = data;
        tick();
        bus.io_wr   = 1'b0;
    endtask

    task automatic busRead(input logic [15:0] addr, output logic [15:0] data);
        bus.io_rd   = 1'b1;
        bus.io_addr = addr;
        tick();
        bus.io_rd   = 1'b0;
        data        = bus.io_din;
    endtask

    logic [15:0] rd;
    logic [7:0]  exp_q [$];
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
    int          guard;

    initial begin
        assert_count = 0;
        fail_count   = 0;
        rst          = 1'b1;
        bus.io_rd    = 1'b0;
        bus.io_wr    = 1'b0;
        bus.io_addr  = '0;
        bus.io_dout  = '0;
        bus.tx_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        checkOutput("rst_tx_valid", bus.tx_valid, 0);
        checkOutput("rst_io_din", bus.io_din, 0);
        checkOutput("rst_exit_req", bus.exit_req, 0);
        checkOutput("rst_exit_code", bus.exit_code, 0);
        rst = 1'b0;
        busRead(16'h2001, rd);
        checkOutput("rst_status", rd, 16'h2000);

        // "Hi" streams straight through with the sink ready
        bus.tx_ready = 1'b1;
        applyStimulus(16'h2000, 16'h0048);
        checkOutput("hi_valid0", bus.tx_valid, 1);
        checkOutput("hi_data0", bus.tx_data, 8'h48);
        applyStimulus(16'h2000, 16'h0069);
        checkOutput("hi_valid1", bus.tx_valid, 1);
        checkOutput("hi_data1", bus.tx_data, 8'h69);
        tick();
        checkOutput("hi_drained", bus.tx_valid, 0);
        bus.tx_ready = 1'b0;
        busRead(16'h2001, rd);
        checkOutput("hi_status", rd, 16'h2000);

        // Overflow: 17 pushes into a 16-deep FIFO with the sink stalled
        for (int i = 0; i < 17; i++) applyStimulus(16'h2000, 16'(16'h0041 + i));
        busRead(16'h2001, rd);
        checkOutput("ovf_status", rd, 16'hC010);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("ovf_drain%0d", i), bus.tx_data, 32'(8'h41 + i));
            tick();
        end
        checkOutput("ovf_empty", bus.tx_valid, 0);
        bus.tx_ready = 1'b0;
        applyStimulus(16'h2001, 16'h8000);
        busRead(16'h2001, rd);
        checkOutput("ovf_cleared", rd, 16'h2000);

        // Push into a full FIFO while it pops in the same cycle
        exp_q.delete();
        for (int i = 0; i < 16; i++) applyStimulus(16'h2000, 16'(16'h0030 + i));
        for (int i = 1; i < 16; i++) exp_q.push_back(8'(8'h30 + i));
        exp_q.push_back(8'h5A);
        bus.tx_ready = 1'b1;
        applyStimulus(16'h2000, 16'h005A);
        bus.tx_ready = 1'b0;
        busRead(16'h2001, rd);
        checkOutput("fullpush_status", rd, 16'h4010);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("fullpush_drain%0d", i), bus.tx_data, exp_q[i]);
            tick();
        end
        checkOutput("fullpush_empty", bus.tx_valid, 0);
        bus.tx_ready = 1'b0;

        // Exit waits for the console to drain; second write before exit overwrites
        for (int i = 0; i < 3; i++) applyStimulus(16'h2000, 16'(16'h0061 + i));
        applyStimulus(16'hFFFF, 16'h0041);
        applyStimulus(16'hFFFF, 16'h0042);
        checkOutput("exit_code_overwrite", bus.exit_code, 8'h42);
        busRead(16'h2001, rd);
        checkOutput("exit_pending_status", rd, 16'h1003);
        checkOutput("exit_req_held", bus.exit_req, 0);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("exit_req_pop%0d", i), bus.exit_req, 0);
        end
        checkOutput("exit_fifo_empty", bus.tx_valid, 0);
        tick();
        checkOutput("exit_req_set", bus.exit_req, 1);
        checkOutput("exit_code", bus.exit_code, 8'h42);
        applyStimulus(16'hFFFF, 16'h0077);
        checkOutput("exit_code_locked", bus.exit_code, 8'h42);
        bus.tx_ready = 1'b0;
        busRead(16'h2001, rd);
        checkOutput("exit_status", rd, 16'h3000);
        busRead(16'hFFFF, rd);
        checkOutput("exit_read_zero", rd, 0);
        busRead(16'h2001, rd);
        busRead(16'h1234, rd);
        checkOutput("unmapped_read_zero", rd, 0);

        // Asynchronous reset in the middle of a queued transfer
        for (int i = 0; i < 5; i++) applyStimulus(16'h2000, 16'(16'h0070 + i));
        busRead(16'h2001, rd);
        checkOutput("prereset_status", rd, 16'h1005);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_tx_valid", bus.tx_valid, 0);
        checkOutput("async_io_din", bus.io_din, 0);
        checkOutput("async_exit_req", bus.exit_req, 0);
        tick();
        rst = 1'b0;
        busRead(16'h2001, rd);
        checkOutput("postreset_status", rd, 16'h2000);

        // Cycle counter: CYC_HI returns the upper half latched by the CYC_LO read
        guard = 0;
        while (model_cycle != 32'h0000FFFF && guard < 100000) begin
            tick();
            guard++;
        end
        checkOutput("cycle_wait_in_budget", guard < 100000, 1);
        busRead(16'h2002, rd);
        checkOutput("cyc_lo_ffff", rd, 16'hFFFF);
        busRead(16'h2003, rd);
        checkOutput("cyc_hi_shadow", rd, 16'h0000);
        exp_lo = model_cycle[15:0];
        exp_hi = model_cycle[31:16];
        busRead(16'h2002, rd);
        checkOutput("cyc_lo_after_wrap", rd, exp_lo);
        busRead(16'h2003, rd);
        checkOutput("cyc_hi_after_wrap", rd, exp_hi);
        checkOutput("cyc_hi_is_one", exp_hi, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
